// File: rtl/test_pkg.sv
// rtl/test_pkg.sv - shared encodings and constants for the voting-machine controller
package test_pkg;

    // Controller state encodings; codes 5-15 are illegal and recover to IDLE.
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WAIT_D1   = 4'd1;
    localparam logic [3:0] ST_WAIT_D2   = 4'd2;
    localparam logic [3:0] ST_WAIT_CONF = 4'd3;
    localparam logic [3:0] ST_FINISHED  = 4'd4;

    // Result of the last confirmation.
    localparam logic [1:0] VS_NONE = 2'b00;
    localparam logic [1:0] VS_C1   = 2'b01;
    localparam logic [1:0] VS_C2   = 2'b10;
    localparam logic [1:0] VS_NULL = 2'b11;

    // Candidate A is "13", candidate B is "22".
    localparam logic [3:0] CAND_A_D1 = 4'd1;
    localparam logic [3:0] CAND_A_D2 = 4'd3;
    localparam logic [3:0] CAND_B_D1 = 4'd2;
    localparam logic [3:0] CAND_B_D2 = 4'd2;

    // Display code for an empty digit position.
    localparam logic [3:0] BLANK = 4'hF;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: a counter at full scale stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/test_vote_decoder.sv
// rtl/test_vote_decoder.sv - maps the two entered digits and swap to a vote_status code
module test_vote_decoder
    import test_pkg::*;
(
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic       swap,
    output logic [1:0] vote_status
);

    logic is_a;
    logic is_b;

    assign is_a = (digit1 == CAND_A_D1) && (digit2 == CAND_A_D2);
    assign is_b = (digit1 == CAND_B_D1) && (digit2 == CAND_B_D2);

    // Anything that is not exactly a candidate number (including digits >9) is a null vote.
    always_comb begin
        vote_status = VS_NULL;
        if (is_a) begin
            vote_status = swap ? VS_C2 : VS_C1;
        end else if (is_b) begin
            vote_status = swap ? VS_C1 : VS_C2;
        end
    end

endmodule

// File: rtl/test.sv
// rtl/test.sv - voting-machine controller top; URNA_SWAP_EN enables the swap input
module test
    import test_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       digit,
    input  logic             valid,
    input  logic             start,
    input  logic             finish,
    input  logic             swap,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [1:0]       vote_status,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] C1,
    output logic [CNT_W-1:0] C2,
    output logic [CNT_W-1:0] Nulo
);

    logic [3:0]       state_q, state_d;
    logic             valid_q;
    logic [3:0]       digit1_q, digit1_d;
    logic [3:0]       digit2_q, digit2_d;
    logic [1:0]       status_q, status_d;
    logic [CNT_W-1:0] c1_q, c1_d;
    logic [CNT_W-1:0] c2_q, c2_d;
    logic [CNT_W-1:0] nulo_q, nulo_d;
    logic             accept;
    logic             swap_eff;
    logic [1:0]       dec_status;

    // A keypress counts once: valid high now, low at the previous edge.
    assign accept = valid & ~valid_q;

`ifdef URNA_SWAP_EN
    assign swap_eff = swap;
`else
    // The port stays for pin compatibility but the mapping is fixed.
    assign swap_eff = swap & 1'b0;
`endif

    test_vote_decoder u_vote_decoder (
        .digit1      (digit1_q),
        .digit2      (digit2_q),
        .swap        (swap_eff),
        .vote_status (dec_status)
    );

    // State register and valid edge-detect history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid;
        end
    end

    // Next-state logic; finish takes priority over a keypress while voting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FINISHED: if (accept && start) state_d = ST_WAIT_D1;
            ST_WAIT_D1:   if (finish) state_d = ST_FINISHED; else if (accept) state_d = ST_WAIT_D2;
            ST_WAIT_D2:   if (finish) state_d = ST_FINISHED; else if (accept) state_d = ST_WAIT_CONF;
            ST_WAIT_CONF: if (finish) state_d = ST_FINISHED; else if (accept) state_d = ST_WAIT_D1;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: digit capture, vote counting and election clear.
    always_comb begin
        digit1_d = digit1_q;
        digit2_d = digit2_q;
        status_d = status_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        nulo_d   = nulo_q;
        case (state_q)
            ST_IDLE, ST_FINISHED: begin
                if (accept && start) begin
                    digit1_d = BLANK;
                    digit2_d = BLANK;
                    status_d = VS_NONE;
                    c1_d     = '0;
                    c2_d     = '0;
                    nulo_d   = '0;
                end
            end
            ST_WAIT_D1: begin
                if (finish) begin
                    digit1_d = BLANK;
                    digit2_d = BLANK;
                end else if (accept) begin
                    digit1_d = digit;
                    digit2_d = BLANK;
                    status_d = VS_NONE;
                end
            end
            ST_WAIT_D2: begin
                if (finish) begin
                    digit1_d = BLANK;
                    digit2_d = BLANK;
                end else if (accept) begin
                    digit2_d = digit;
                end
            end
            ST_WAIT_CONF: begin
                digit1_d = BLANK;
                digit2_d = BLANK;
                if (finish) begin
                    digit1_d = BLANK;
                end else if (accept) begin
                    status_d = dec_status;
                    case (dec_status)
                        VS_C1:   c1_d   = sat_inc(c1_q);
                        VS_C2:   c2_d   = sat_inc(c2_q);
                        default: nulo_d = sat_inc(nulo_q);
                    endcase
                end else begin
                    digit1_d = digit1_q;
                    digit2_d = digit2_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit1_q <= BLANK;
            digit2_q <= BLANK;
            status_q <= VS_NONE;
            c1_q     <= '0;
            c2_q     <= '0;
            nulo_q   <= '0;
        end else begin
            digit1_q <= digit1_d;
            digit2_q <= digit2_d;
            status_q <= status_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            nulo_q   <= nulo_d;
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        state       = state_q;
        digit1      = digit1_q;
        digit2      = digit2_q;
        vote_status = status_q;
        C1          = c1_q;
        C2          = c2_q;
        Nulo        = nulo_q;
    end

endmodule

// File: tb/tb_test.sv
// tb/tb_test.sv - directed self-checking bench for the voting-machine controller
module tb_test;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] digit;
    logic       valid;
    logic       start;
    logic       finish;
    logic       swap;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [1:0] vote_status;
    logic [3:0] state;
    logic [7:0] C1;
    logic [7:0] C2;
    logic [7:0] Nulo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] d1;
        logic [3:0] d2;
        logic       sw;
        logic [1:0] st;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] nu;
    } vote_t;

    vote_t vt[8];

    test dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .digit       (digit),
        .valid       (valid),
        .start       (start),
        .finish      (finish),
        .swap        (swap),
        .digit1      (digit1),
        .digit2      (digit2),
        .vote_status (vote_status),
        .state       (state),
        .C1          (C1),
        .C2          (C2),
        .Nulo        (Nulo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One keypress: valid high across one rising edge, then low across the next.
    task automatic press(input logic [3:0] d, input logic s, input logic f);
        @(negedge clock);
        digit  = d;
        valid  = 1'b1;
        start  = s;
        finish = f;
        @(negedge clock);
        valid  = 1'b0;
        start  = 1'b0;
        finish = 1'b0;
    endtask

    task automatic vote(input logic [3:0] d1, input logic [3:0] d2);
        press(d1, 1'b0, 1'b0);
        press(d2, 1'b0, 1'b0);
        press(4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_counts(input string name, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] nu);
        chk({name, ".C1"}, C1, c1);
        chk({name, ".C2"}, C2, c2);
        chk({name, ".Nulo"}, Nulo, nu);
    endtask

    initial begin
        vt[0] = '{4'd5, 4'd1, 1'b0, 2'b11, 8'd0, 8'd0, 8'd1};
        vt[1] = '{4'd1, 4'd3, 1'b0, 2'b01, 8'd1, 8'd0, 8'd1};
        vt[2] = '{4'd2, 4'd2, 1'b0, 2'b10, 8'd1, 8'd1, 8'd1};
        vt[3] = '{4'd1, 4'd3, 1'b0, 2'b01, 8'd2, 8'd1, 8'd1};
        vt[4] = '{4'd2, 4'd0, 1'b0, 2'b11, 8'd2, 8'd1, 8'd2};
        vt[5] = '{4'd1, 4'd2, 1'b0, 2'b11, 8'd2, 8'd1, 8'd3};
`ifdef URNA_SWAP_EN
        vt[6] = '{4'd1, 4'd3, 1'b1, 2'b10, 8'd2, 8'd2, 8'd3};
        vt[7] = '{4'd2, 4'd2, 1'b1, 2'b01, 8'd3, 8'd2, 8'd3};
`else
        vt[6] = '{4'd1, 4'd3, 1'b1, 2'b01, 8'd3, 8'd1, 8'd3};
        vt[7] = '{4'd2, 4'd2, 1'b1, 2'b10, 8'd3, 8'd2, 8'd3};
`endif

        reset_n = 1'b0;
        digit   = 4'd0;
        valid   = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;
        swap    = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst.state", state, 4'd0);
        chk("rst.digit1", digit1, 4'hF);
        chk("rst.digit2", digit2, 4'hF);
        chk("rst.status", vote_status, 2'b00);
        chk_counts("rst", 8'd0, 8'd0, 8'd0);
        reset_n = 1'b1;

        // Valid without start in IDLE is ignored.
        press(4'd0, 1'b0, 1'b0);
        chk("idle_nostart.state", state, 4'd0);

        // First election: a null vote then candidate A, then close.
        press(4'd0, 1'b1, 1'b0);
        chk("e1_open.state", state, 4'd1);
        press(4'd9, 1'b0, 1'b0);
        chk("e1_d1.state", state, 4'd2);
        chk("e1_d1.digit1", digit1, 4'd9);
        chk("e1_d1.digit2", digit2, 4'hF);
        press(4'd1, 1'b0, 1'b0);
        chk("e1_d2.state", state, 4'd3);
        chk("e1_d2.digit2", digit2, 4'd1);
        press(4'd0, 1'b0, 1'b0);
        chk("e1_v1.status", vote_status, 2'b11);
        chk("e1_v1.state", state, 4'd1);
        chk("e1_v1.digit1", digit1, 4'hF);
        chk_counts("e1_v1", 8'd0, 8'd0, 8'd1);
        press(4'd1, 1'b0, 1'b0);
        chk("e1_v2d1.status", vote_status, 2'b00);
        press(4'd3, 1'b0, 1'b0);
        press(4'd0, 1'b0, 1'b0);
        chk("e1_v2.status", vote_status, 2'b01);
        @(negedge clock);
        finish = 1'b1;
        @(negedge clock);
        finish = 1'b0;
        chk("e1_fin.state", state, 4'd4);
        chk_counts("e1_fin", 8'd1, 8'd0, 8'd1);

        // In FINISHED: finish and plain keypresses change nothing.
        press(4'd1, 1'b0, 1'b1);
        chk("fin_ign.state", state, 4'd4);
        chk_counts("fin_ign", 8'd1, 8'd0, 8'd1);

        // Second election: table of votes, swap changes mapping at confirmation.
        press(4'd0, 1'b1, 1'b0);
        chk("e2_open.state", state, 4'd1);
        chk_counts("e2_open", 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            swap = vt[i].sw;
            vote(vt[i].d1, vt[i].d2);
            chk($sformatf("vt%0d.status", i), vote_status, vt[i].st);
            chk($sformatf("vt%0d.state", i), state, 4'd1);
            chk_counts($sformatf("vt%0d", i), vt[i].c1, vt[i].c2, vt[i].nu);
        end
        swap = 1'b0;

        // Finish together with a keypress: finish wins, partial vote dropped.
        press(4'd1, 1'b0, 1'b0);
        chk("fv_d1.digit1", digit1, 4'd1);
        press(4'd3, 1'b0, 1'b1);
        chk("fv.state", state, 4'd4);
        chk("fv.digit1", digit1, 4'hF);
        chk("fv.digit2", digit2, 4'hF);
        chk_counts("fv", 8'd3, 8'd2, 8'd3);

        // Holding valid high is one keypress only; start mid-vote is ignored.
        press(4'd0, 1'b1, 1'b0);
        @(negedge clock);
        digit = 4'd7;
        valid = 1'b1;
        repeat (5) @(negedge clock);
        valid = 1'b0;
        chk("hold.state", state, 4'd2);
        chk("hold.digit1", digit1, 4'd7);
        chk("hold.digit2", digit2, 4'hF);
        press(4'd3, 1'b1, 1'b0);
        chk("start_ign.state", state, 4'd3);
        chk("start_ign.digit2", digit2, 4'd3);

        // Asynchronous reset in WAIT_CONF takes effect before the next edge.
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("areset.state", state, 4'd0);
        chk("areset.digit1", digit1, 4'hF);
        chk("areset.digit2", digit2, 4'hF);
        chk("areset.status", vote_status, 2'b00);
        chk_counts("areset", 8'd0, 8'd0, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Saturation: 256 null votes leave Nulo at 255.
        press(4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            vote(4'd9, 4'd9);
            if (i == 253) chk("sat254.Nulo", Nulo, 8'd254);
            if (i == 254) chk("sat255.Nulo", Nulo, 8'd255);
        end
        chk_counts("sat256", 8'd0, 8'd0, 8'd255);
        chk("sat256.status", vote_status, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
